// File: rtl/song_pkg.sv
// rtl/song_pkg.sv - shared widths, song ROM entry layout and FSM states for song_reader
package song_pkg;

  localparam int ADDR_W  = 9;
  localparam int NOTE_W  = 6;
  localparam int DUR_W   = 6;
  localparam int ENTRY_W = NOTE_W + DUR_W + 1;

  // Entry layout: {chord_cont, note, duration}
  localparam int CHORD_CONT_BIT = NOTE_W + DUR_W;
  localparam int NOTE_LSB       = DUR_W;
  localparam int DUR_LSB        = 0;

  localparam logic [NOTE_W-1:0] REST_NOTE = '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    DECODE,
    ADVANCE,
    WAIT_DONE,
    DONE
  } state_t;

endpackage

// File: rtl/voice_slot.sv
// rtl/voice_slot.sv - one voice: holds the loaded note, its full duration and the beats still to play
module voice_slot
  import song_pkg::*;
#(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [NOTE_W-1:0] i_note,
  input  logic [DUR_W-1:0]  i_dur,
  input  logic              i_sub,
  input  logic [DUR_W-1:0]  i_sub_amt,
  output logic [NOTE_W-1:0] o_note,
  output logic [DUR_W-1:0]  o_duration,
  output logic [DUR_W-1:0]  o_remaining,
  output logic              o_free
);

  logic [NOTE_W-1:0] r_note;
  logic [DUR_W-1:0]  r_dur;
  logic [DUR_W-1:0]  r_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_note <= NOTE_W'(REST_NOTE);
      r_dur  <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_note <= i_note;
      r_dur  <= i_dur;
      r_rem  <= i_dur;
    end else if (i_sub && (r_rem != '0)) begin
      // Advances are the minimum active remaining, so this never wraps
      r_rem <= r_rem - i_sub_amt;
    end
  end

  assign o_note      = r_note;
  assign o_duration  = r_dur;
  assign o_remaining = r_rem;
  assign o_free      = (r_rem == '0);

endmodule

// File: rtl/song_reader.sv
// rtl/song_reader.sv - walks the song ROM, loads three voice slots and paces chord_player with time advances
// SONG_LOOP_EN: wrap to address 0 at end of song instead of stopping with a sticky song_done.
module song_reader
  import song_pkg::*;
#(
  parameter int ADDR_W  = song_pkg::ADDR_W,
  parameter int NOTE_W  = song_pkg::NOTE_W,
  parameter int DUR_W   = song_pkg::DUR_W,
  parameter int ROM_LAT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [NOTE_W+DUR_W:0]     rom_data,
  output logic [NOTE_W-1:0]         note1,
  output logic [NOTE_W-1:0]         note2,
  output logic [NOTE_W-1:0]         note3,
  output logic [DUR_W-1:0]          duration1,
  output logic [DUR_W-1:0]          duration2,
  output logic [DUR_W-1:0]          duration3,
  output logic                      new_note1,
  output logic                      new_note2,
  output logic                      new_note3,
  output logic [DUR_W-1:0]          time_advance,
  output logic                      time_advance_ready,
  input  logic                      advance_done,
  output logic                      song_done
);

  localparam int EW     = NOTE_W + DUR_W + 1;
  localparam int WAIT_W = (ROM_LAT < 2) ? 1 : $clog2(ROM_LAT + 1);

  state_t            r_state;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [WAIT_W-1:0] r_wait;
  logic              r_pend;
  logic [EW-1:0]     r_pend_entry;
  logic [2:0]        r_new_note;
  logic [DUR_W-1:0]  r_time_adv;
  logic              r_ta_ready;
  logic              r_song_done;

  logic [EW-1:0]     w_entry;
  logic              w_cont;
  logic [NOTE_W-1:0] w_note;
  logic [DUR_W-1:0]  w_dur;
  logic [2:0]        w_free;
  logic [2:0]        w_sel;
  logic              w_any_free;
  logic              w_free_after;
  logic [2:0]        w_load;
  logic              w_sub;
  logic              w_any_active;
  logic [DUR_W-1:0]  w_min;
  logic [DUR_W-1:0]  w_rem [3];

  // A held (pending) entry takes priority over the ROM read path
  assign w_entry = r_pend ? r_pend_entry : rom_data;
  assign w_cont  = w_entry[NOTE_W+DUR_W];
  assign w_note  = w_entry[DUR_W +: NOTE_W];
  assign w_dur   = w_entry[DUR_W-1:0];

  always_comb begin
    w_sel = 3'b000;
    if (w_free[0])      w_sel = 3'b001;
    else if (w_free[1]) w_sel = 3'b010;
    else if (w_free[2]) w_sel = 3'b100;
  end

  assign w_any_free   = |w_free;
  assign w_free_after = |(w_free & ~w_sel);
  assign w_load       = ((r_state == DECODE) && (w_dur != '0)) ? w_sel : 3'b000;
  assign w_sub        = (r_state == WAIT_DONE) && advance_done;

  always_comb begin
    w_min        = '1;
    w_any_active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (w_rem[i] != '0) begin
        w_any_active = 1'b1;
        if (w_rem[i] < w_min) w_min = w_rem[i];
      end
    end
  end

  voice_slot #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) u_voice1 (
    .clk(clk), .reset(reset), .i_load(w_load[0]), .i_note(w_note), .i_dur(w_dur),
    .i_sub(w_sub), .i_sub_amt(r_time_adv), .o_note(note1), .o_duration(duration1),
    .o_remaining(w_rem[0]), .o_free(w_free[0])
  );

  voice_slot #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) u_voice2 (
    .clk(clk), .reset(reset), .i_load(w_load[1]), .i_note(w_note), .i_dur(w_dur),
    .i_sub(w_sub), .i_sub_amt(r_time_adv), .o_note(note2), .o_duration(duration2),
    .o_remaining(w_rem[1]), .o_free(w_free[1])
  );

  voice_slot #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) u_voice3 (
    .clk(clk), .reset(reset), .i_load(w_load[2]), .i_note(w_note), .i_dur(w_dur),
    .i_sub(w_sub), .i_sub_amt(r_time_adv), .o_note(note3), .o_duration(duration3),
    .o_remaining(w_rem[2]), .o_free(w_free[2])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rom_addr   <= '0;
      r_wait       <= '0;
      r_pend       <= 1'b0;
      r_pend_entry <= '0;
      r_new_note   <= 3'b000;
      r_time_adv   <= '0;
      r_ta_ready   <= 1'b0;
      r_song_done  <= 1'b0;
    end else begin
      r_new_note <= 3'b000;
      r_ta_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (play && !r_song_done) r_state <= FETCH;
        end
        FETCH: begin
          if (r_pend) begin
            r_state <= DECODE;
          end else begin
            r_rom_addr <= r_cnt[ADDR_W-1:0];
            r_cnt      <= r_cnt + 1'b1;
            r_wait     <= WAIT_W'(ROM_LAT - 1);
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (r_wait == '0) r_state <= DECODE;
          else              r_wait  <= r_wait - 1'b1;
        end
        DECODE: begin
          if (w_dur == '0) begin
            r_state <= (w_cont && w_any_free) ? FETCH : ADVANCE;
          end else if (!w_any_free) begin
            r_pend       <= 1'b1;
            r_pend_entry <= w_entry;
            r_state      <= ADVANCE;
          end else begin
            r_pend     <= 1'b0;
            r_new_note <= w_sel;
            r_state    <= (w_cont && w_free_after) ? FETCH : ADVANCE;
          end
        end
        ADVANCE: begin
          if (w_any_active) begin
            r_time_adv <= w_min;
            r_ta_ready <= 1'b1;
            r_state    <= WAIT_DONE;
          end else if (r_cnt[ADDR_W] && !r_pend) begin
            // Song ended on skipped entries only: nothing left to play out
`ifdef SONG_LOOP_EN
            r_cnt   <= '0;
            r_state <= FETCH;
`else
            r_song_done <= 1'b1;
            r_state     <= DONE;
`endif
          end else begin
            r_state <= FETCH;
          end
        end
        WAIT_DONE: begin
          if (advance_done) begin
            if (r_cnt[ADDR_W] && !r_pend) begin
`ifdef SONG_LOOP_EN
              r_cnt   <= '0;
              r_state <= play ? FETCH : IDLE;
`else
              r_song_done <= 1'b1;
              r_state     <= DONE;
`endif
            end else if (play) begin
              r_state <= FETCH;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        DONE: begin
          r_song_done <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rom_addr           = r_rom_addr;
  assign new_note1          = r_new_note[0];
  assign new_note2          = r_new_note[1];
  assign new_note3          = r_new_note[2];
  assign time_advance       = r_time_adv;
  assign time_advance_ready = r_ta_ready;
  assign song_done          = r_song_done;

endmodule

// File: tb/tb_song_reader.sv
// tb/tb_song_reader.sv - scoreboard bench for song_reader with a 2-cycle song ROM model and a chord_player responder
module tb_song_reader;
  import song_pkg::*;

  localparam int AW = 9;
  localparam int NW = 6;
  localparam int DW = 6;
  localparam int EW = NW + DW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          play;
  logic          advance_done;
  logic [AW-1:0] rom_addr;
  logic [EW-1:0] rom_data;
  logic [NW-1:0] note1, note2, note3;
  logic [DW-1:0] duration1, duration2, duration3;
  logic          new_note1, new_note2, new_note3;
  logic [DW-1:0] time_advance;
  logic          time_advance_ready;
  logic          song_done;

  always #5 clk = ~clk;

  song_reader #(.ADDR_W(AW), .NOTE_W(NW), .DUR_W(DW), .ROM_LAT(2)) dut (
    .clk(clk), .reset(reset), .play(play), .rom_addr(rom_addr), .rom_data(rom_data),
    .note1(note1), .note2(note2), .note3(note3),
    .duration1(duration1), .duration2(duration2), .duration3(duration3),
    .new_note1(new_note1), .new_note2(new_note2), .new_note3(new_note3),
    .time_advance(time_advance), .time_advance_ready(time_advance_ready),
    .advance_done(advance_done), .song_done(song_done)
  );

  logic [EW-1:0] mem [512];
  logic [EW-1:0] d1 = '0;
  logic [EW-1:0] d2 = '0;
  always @(posedge clk) begin
    d1 <= mem[rom_addr];
    d2 <= d1;
  end
  assign rom_data = d2;

  typedef struct {
    int kind;
    int a;
    int b;
    int lat;
  } ev_t;
  ev_t q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0, addr_chg = 0, last_note = 0, n_strobes = 0;
  logic [AW-1:0] prev_addr = '0;
  bit auto_ack = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic push(input int k, input int a, input int b, input int lat);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.lat = lat;
    q.push_back(e);
  endtask

  function automatic logic [EW-1:0] ent(input int c, input int n, input int d);
    logic [EW-1:0] e;
    e = '0;
    e[CHORD_CONT_BIT]     = c[0];
    e[NOTE_LSB +: NOTE_W] = n[NOTE_W-1:0];
    e[DUR_LSB +: DUR_W]   = d[DUR_W-1:0];
    return e;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = '0;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_rom_addr"}, int'(rom_addr), 0);
    chk({nm, "_strobes"}, int'({new_note1, new_note2, new_note3, time_advance_ready}), 0);
    chk({nm, "_values"}, int'(|{note1, note2, note3, duration1, duration2, duration3, time_advance}), 0);
    chk({nm, "_song_done"}, int'(song_done), 0);
  endtask

  task automatic drain(input string nm, input int limit);
    int t;
    t = 0;
    while (q.size() != 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_drained"}, q.size(), 0);
    q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; play = 1'b0; auto_ack = 1'b0; advance_done = 1'b0;
    repeat (2) @(negedge clk);
    q.delete();
  endtask

  // Scoreboard monitor: every strobe pops one expected event
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rom_addr != prev_addr) begin
      addr_chg  = cyc;
      prev_addr = rom_addr;
    end
    if (!reset && (new_note1 || new_note2 || new_note3 || time_advance_ready)) begin
      int k, a, b, nh;
      ev_t e;
      nh = int'(new_note1) + int'(new_note2) + int'(new_note3) + int'(time_advance_ready);
      n_strobes++;
      chk("strobe_onehot", nh, 1);
      if (new_note1)      begin k = 1; a = int'(note1); b = int'(duration1); end
      else if (new_note2) begin k = 2; a = int'(note2); b = int'(duration2); end
      else if (new_note3) begin k = 3; a = int'(note3); b = int'(duration3); end
      else                begin k = 4; a = int'(time_advance); b = 0; end
      if (q.size() == 0) begin
        chk("unexpected_strobe_kind", k, 0);
      end else begin
        e = q.pop_front();
        chk("strobe_kind", k, e.kind);
        chk("strobe_value", a, e.a);
        chk("strobe_duration", b, e.b);
        if (e.lat == 1) chk("rom_to_note_latency", cyc - addr_chg, 3);
        if (e.lat == 2) chk("decode_to_ready_latency", cyc - last_note, 1);
      end
      if (k != 4) last_note = cyc;
    end
  end

  // chord_player stand-in: acknowledge each advance a few cycles later
  initial forever begin
    @(negedge clk);
    if (time_advance_ready && !reset && auto_ack) begin
      repeat (3) @(negedge clk);
      if (auto_ack && !reset) begin
        advance_done = 1'b1;
        @(negedge clk);
        advance_done = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s, t, got;
    reset = 1'b1; play = 1'b0; advance_done = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_zero("reset");

    // Single notes
    mem[0] = ent(0, 12, 4);
    mem[1] = ent(0, 14, 2);
    push(1, 12, 4, 0); push(4, 4, 0, 2); push(1, 14, 2, 1); push(4, 2, 0, 2);
    reset = 1'b0; auto_ack = 1'b1; play = 1'b1;
    drain("single", 300);
    do_reset();

    // Chord, then refill of the first voice to free up
    clear_mem();
    mem[0] = ent(1, 10, 8); mem[1] = ent(1, 14, 4); mem[2] = ent(0, 17, 6);
    mem[3] = ent(0, 20, 2); mem[4] = ent(0, 21, 1);
    push(1, 10, 8, 0); push(2, 14, 4, 0); push(3, 17, 6, 0); push(4, 4, 0, 2);
    push(2, 20, 2, 1); push(4, 2, 0, 2); push(2, 21, 1, 0); push(4, 1, 0, 2);
    reset = 1'b0; auto_ack = 1'b1; play = 1'b1;
    drain("chord", 400);
    do_reset();

    // Four-entry chord: fourth entry waits for a freed voice
    clear_mem();
    mem[0] = ent(1, 10, 2); mem[1] = ent(1, 12, 4); mem[2] = ent(1, 14, 6); mem[3] = ent(0, 16, 3);
    push(1, 10, 2, 0); push(2, 12, 4, 0); push(3, 14, 6, 0); push(4, 2, 0, 2);
    push(1, 16, 3, 1); push(4, 2, 0, 2);
    reset = 1'b0; auto_ack = 1'b1; play = 1'b1;
    drain("overflow_chord", 400);
    do_reset();

    // Skipped entry and pause across an advance
    clear_mem();
    mem[0] = ent(0, 9, 0); mem[1] = ent(0, 7, 5); mem[2] = ent(0, 0, 1);
    push(1, 7, 5, 0); push(4, 5, 0, 2);
    reset = 1'b0; auto_ack = 1'b1; play = 1'b1;
    drain("skip", 300);
    auto_ack = 1'b0; play = 1'b0;
    repeat (2) @(negedge clk);
    advance_done = 1'b1;
    @(negedge clk);
    advance_done = 1'b0;
    s = n_strobes;
    repeat (20) @(negedge clk);
    chk("pause_no_strobe", n_strobes - s, 0);
    chk("pause_rom_addr", int'(rom_addr), 1);
    push(1, 0, 1, 1); push(4, 1, 0, 2);
    auto_ack = 1'b1; play = 1'b1;
    drain("resume", 300);
    do_reset();

    // End of song
    clear_mem();
    mem[511] = ent(0, 5, 3);
    push(1, 5, 3, 0); push(4, 3, 0, 2);
    reset = 1'b0; auto_ack = 1'b1; play = 1'b1;
    drain("end_of_song", 4000);
    repeat (10) @(negedge clk);
`ifdef SONG_LOOP_EN
    chk("loop_song_done", int'(song_done), 0);
    chk("loop_rom_addr", int'(rom_addr), 0);
`else
    chk("song_done_set", int'(song_done), 1);
    s = n_strobes;
    play = 1'b0;
    repeat (5) @(negedge clk);
    play = 1'b1;
    repeat (30) @(negedge clk);
    chk("song_done_sticky", int'(song_done), 1);
    chk("done_no_strobe", n_strobes - s, 0);
`endif
    do_reset();

    // Reset while decoding the second chord entry
    clear_mem();
    mem[0] = ent(1, 10, 8); mem[1] = ent(1, 14, 4); mem[2] = ent(0, 17, 6);
    push(1, 10, 8, 0);
    reset = 1'b0; auto_ack = 1'b1; play = 1'b1;
    got = 0; t = 0;
    while (!got && t < 50) begin
      @(negedge clk);
      t++;
      if (new_note1) got = 1;
    end
    chk("midreset_first_note", got, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1; play = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    chk("midreset_queue", q.size(), 0);
    q.delete();
    @(negedge clk);
    push(1, 10, 8, 0); push(2, 14, 4, 0); push(3, 17, 6, 0); push(4, 4, 0, 2);
    reset = 1'b0; auto_ack = 1'b1; play = 1'b1;
    drain("after_reset", 300);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/song_reader.md
Name: song_reader

Overview:
- Upstream feeder of chord_player.
- Walks the song ROM and assigns each note entry to one of three voice slots.
- Pulses new_noteN with that slot's note and duration.
- Owns all song timing: issues time_advance equal to the shortest remaining duration among active voices, so an advance never exceeds any playing note. It then waits for chord_player to finish that advance before fetching again.

Parameters:
- ADDR_W, 9, song ROM address width (512 entries)
- NOTE_W, 6, note code width
- DUR_W, 6, duration width (beats)
- ROM_LAT, 2, cycles from rom_addr to valid rom_data

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- play  in  1  level; 1 = run, 0 = pause (held in WAIT_DONE/IDLE)
- rom_addr  out  ADDR_W  song ROM address
- rom_data  in  NOTE_W+DUR_W+1  {chord_cont, note, duration}
- note1, note2, note3  out  NOTE_W  note code per voice
- duration1, duration2, duration3  out  DUR_W  full duration of newly loaded note
- new_note1, new_note2, new_note3  out  1  1-cycle load strobe per voice
- time_advance  out  DUR_W  beats chord_player plays before the next event
- time_advance_ready  out  1  1-cycle strobe, time_advance valid
- advance_done  in  1  1-cycle strobe from chord_player, advance elapsed
- song_done  out  1  sticky; set when address counter overflows into bit ADDR_W

Behaviour:
- Reset values:
  - all outputs 0
  - internal address counter (ADDR_W+1 bits) = 0
  - remaining[1..3] = 0, pending flag = 0
  - state IDLE
- Entry fields:
  - chord_cont (MSB): next entry starts at the same time as this one
  - note = 0 is a rest that still occupies a voice
  - duration 0 entries are skipped and occupy no voice
- A voice is free when remaining == 0.

State machine:
- IDLE: play=1 and song_done=0 -> FETCH.
- FETCH:
  - if a held pending entry exists, use it directly -> DECODE
  - else drive rom_addr = counter[ADDR_W-1:0], increment counter -> WAIT (ROM_LAT cycles) -> DECODE
- DECODE:
  - assign the entry to the lowest-numbered free voice
  - in the same cycle, set noteN, durationN, remainingN = duration, and pulse new_noteN
  - then:
    - chord_cont=1 and a free voice remains -> FETCH
    - chord_cont=1 and no free voice -> ADVANCE
    - chord_cont=0 -> ADVANCE
  - no free voice on arrival: hold the entry as pending (not consumed) -> ADVANCE
- ADVANCE:
  - time_advance = minimum non-zero remaining; pulse time_advance_ready for 1 cycle -> WAIT_DONE
  - if no voice is active (all entries skipped): -> FETCH without a pulse
- WAIT_DONE: on advance_done, every active remaining -= time_advance (never underflows by construction).
  - if counter bit ADDR_W is set and no pending entry -> DONE
  - elif play=1 -> FETCH
  - else -> IDLE (pause)
- DONE: song_done = 1; no further strobes. Only reset leaves DONE.

Boundary conditions:
- Overflow check happens after the advance completes, so the last chord still plays out.
- advance_done outside WAIT_DONE is ignored.
- play falling mid-FETCH/DECODE completes the current chord first.
- Reset mid-operation returns every output and state to its reset value on the next edge; no partial strobes.
- At most one new_noteN is high per cycle.

Latency:
- Non-pending entry: rom_addr to new_noteN = ROM_LAT+1 cycles.
- Last decode to time_advance_ready = 1 cycle.

Optional Feature:
- SONG_LOOP_EN defined: when the counter overflows in WAIT_DONE, clear counter to 0 and continue with FETCH. song_done stays 0.
- Undefined: behaviour as above (DONE state, sticky song_done).

Decomposition:
- song_pkg:
  - NOTE_W, DUR_W, ADDR_W constants
  - entry field bit positions (CHORD_CONT_BIT, NOTE_LSB, DUR_LSB)
  - state enum {IDLE, FETCH, WAIT, DECODE, ADVANCE, WAIT_DONE, DONE}
  - REST_NOTE = 0
- Sub-module voice_slot, instantiated 3x:
  - holds note, duration, remaining
  - load strobe and subtract-by-advance input
  - free flag output
- Min-of-three selection stays in song_reader.

Test Plan:
- Single notes:
  - ROM[0]={0,12,4}, ROM[1]={0,14,2}
  - expect new_note1 with note1=12, duration1=4, then time_advance=4 pulse
  - after advance_done, new_note1 with note1=14, then time_advance=2
- Chord:
  - ROM[0..2] = {1,10,8}, {1,14,4}, {0,17,6}
  - expect new_note1/2/3 on successive decodes, time_advance=4
  - after done, voice2 free and next entry loads voice2; remaining voice1=4, voice3=2 -> next advance ≤2
- Overflow chord:
  - four entries all chord_cont=1 except the last
  - fourth entry held pending
  - after first advance_done it loads the freed voice with no new ROM read (rom_addr unchanged)
- Skip and pause:
  - duration-0 entry: produces no new_note strobe
  - play=0 during WAIT_DONE: after advance_done, no fetch until play=1
- End of song:
  - 512 entries, last {0,5,3}; time_advance=3, then advance_done
  - expect song_done=1 sticky, no further strobes
  - with SONG_LOOP_EN: expect rom_addr=0 on the next fetch and song_done=0
- Reset mid-chord: assert reset in DECODE -> all outputs 0 next cycle, first fetch from address 0 afterwards.
